// File: rtl/cdb_result_broadcaster_if.sv
// Result broadcast bus bundle: two execution result sources in, one tag/value broadcast out.
// The slave modport is the broadcaster side; master is the execute/snoop side.
interface cdb_result_broadcaster_if #(
  parameter int unsigned ROBsize = 16,
  parameter int unsigned DEPTH   = 4
);
  localparam int unsigned ROBsizeLog = $clog2(ROBsize + 1);
  localparam int unsigned OCC_W      = $clog2(DEPTH + 1);

  logic                  needToRestore_i;
  logic                  src0Valid_i;
  logic [ROBsizeLog-1:0] src0Tag_i;
  logic [63:0]           src0Val_i;
  logic                  src0Ready_o;
  logic                  src1Valid_i;
  logic [ROBsizeLog-1:0] src1Tag_i;
  logic [63:0]           src1Val_i;
  logic                  src1Ready_o;
  logic                  cdbStall_i;
  logic [ROBsizeLog-1:0] cdbTag_o;
  logic [64:0]           cdbVal_o;
  logic [OCC_W-1:0]      occupancy_o;

  modport slave (
    input  needToRestore_i, src0Valid_i, src0Tag_i, src0Val_i,
           src1Valid_i, src1Tag_i, src1Val_i, cdbStall_i,
    output src0Ready_o, src1Ready_o, cdbTag_o, cdbVal_o, occupancy_o
  );

  modport master (
    output needToRestore_i, src0Valid_i, src0Tag_i, src0Val_i,
           src1Valid_i, src1Tag_i, src1Val_i, cdbStall_i,
    input  src0Ready_o, src1Ready_o, cdbTag_o, cdbVal_o, occupancy_o
  );
endinterface

// File: rtl/cdb_result_broadcaster.sv
// Queues ALU/memory results in a small FIFO and broadcasts one tag/value per cycle on a registered bus.
// Optional macro CDB_BYPASS_EN: an empty, unstalled FIFO lets a result go straight to the bus.
module cdb_result_broadcaster #(
  parameter int unsigned ROBsize = 16,
  parameter int unsigned DEPTH   = 4
) (
  input logic                    clk_i,
  input logic                    reset_i,
  cdb_result_broadcaster_if.slave bus
);
  localparam int unsigned TAG_W = $clog2(ROBsize + 1);
  localparam int unsigned VAL_W = 64;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_d [DEPTH];
  logic [VAL_W-1:0] val_mem_q [DEPTH];
  logic [VAL_W-1:0] val_mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wr1_idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [VAL_W:0]   cdb_val_q, cdb_val_d;
  logic             ready0, ready1, enq0, enq1, wr0, wr1, byp0, byp1, pop, empty, flush;

  // Next-state for FIFO storage, pointers, count and the broadcast register
  always_comb begin
    flush   = reset_i | bus.needToRestore_i;
    empty   = (count_q == '0);
    ready0  = (count_q <= CNT_W'(DEPTH - 1));
    ready1  = (count_q <= CNT_W'(DEPTH - 2));
    enq0    = bus.src0Valid_i & ready0 & (bus.src0Tag_i != '0);
    enq1    = bus.src1Valid_i & ready1 & (bus.src1Tag_i != '0);
`ifdef CDB_BYPASS_EN
    byp0    = empty & ~bus.cdbStall_i & enq0;
    byp1    = empty & ~bus.cdbStall_i & ~bus.src0Valid_i & enq1;
`else
    byp0    = 1'b0;
    byp1    = 1'b0;
`endif
    pop     = ~bus.cdbStall_i & ~empty;
    wr0     = enq0 & ~byp0;
    wr1     = enq1 & ~byp1;
    wr1_idx = PTR_W'(wptr_q + PTR_W'(wr0));

    tag_mem_d = tag_mem_q;
    val_mem_d = val_mem_q;
    if (wr0) begin
      tag_mem_d[wptr_q] = bus.src0Tag_i;
      val_mem_d[wptr_q] = bus.src0Val_i;
    end
    if (wr1) begin
      tag_mem_d[wr1_idx] = bus.src1Tag_i;
      val_mem_d[wr1_idx] = bus.src1Val_i;
    end

    wptr_d  = PTR_W'(wptr_q + PTR_W'(wr0) + PTR_W'(wr1));
    rptr_d  = PTR_W'(rptr_q + PTR_W'(pop));
    count_d = CNT_W'(count_q + CNT_W'(wr0) + CNT_W'(wr1) - CNT_W'(pop));

    cdb_tag_d = cdb_tag_q;
    cdb_val_d = cdb_val_q;
    if (!bus.cdbStall_i) begin
      if (byp0) begin
        cdb_tag_d = bus.src0Tag_i;
        cdb_val_d = {1'b1, bus.src0Val_i};
      end else if (byp1) begin
        cdb_tag_d = bus.src1Tag_i;
        cdb_val_d = {1'b1, bus.src1Val_i};
      end else if (pop) begin
        cdb_tag_d = tag_mem_q[rptr_q];
        cdb_val_d = {1'b1, val_mem_q[rptr_q]};
      end else begin
        cdb_tag_d = '0;
        cdb_val_d = '0;
      end
    end

    // Restore squashes everything in flight, including this cycle's inputs
    if (flush) begin
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      cdb_tag_d = '0;
      cdb_val_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      cdb_tag_q <= '0;
      cdb_val_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      cdb_tag_q <= cdb_tag_d;
      cdb_val_q <= cdb_val_d;
    end
  end

  // Storage carries no reset; pointers and count define validity
  always_ff @(posedge clk_i) begin
    tag_mem_q <= tag_mem_d;
    val_mem_q <= val_mem_d;
  end

  assign bus.src0Ready_o = ready0;
  assign bus.src1Ready_o = ready1;
  assign bus.cdbTag_o    = cdb_tag_q;
  assign bus.cdbVal_o    = cdb_val_q;
  assign bus.occupancy_o = count_q;
endmodule

// File: tb/tb_cdb_result_broadcaster.sv
// Directed and randomized bench for cdb_result_broadcaster against a queue-based reference model.
module tb_cdb_result_broadcaster;
  localparam int unsigned ROBSZ = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = $clog2(ROBSZ + 1);

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [63:0]      val;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_result_broadcaster_if #(.ROBsize(ROBSZ), .DEPTH(DEPTH)) bus ();

  cdb_result_broadcaster #(.ROBsize(ROBSZ), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  ent_t             q[$];
  logic [TAG_W-1:0] m_tag = '0;
  logic [64:0]      m_val = '0;
  logic [TAG_W-1:0] accepted[$];
  logic [TAG_W-1:0] seen[$];
  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [TAG_W-1:0] t, input logic [63:0] v);
    ent_t e;
    e.tag = t;
    e.val = v;
    q.push_back(e);
    accepted.push_back(t);
  endtask

  // One clock cycle: drive, check readiness, advance the model, check the registered outputs
  task automatic cyc(input string name, input logic r, input logic rs, input logic st,
                     input logic v0, input logic [TAG_W-1:0] t0, input logic [63:0] d0,
                     input logic v1, input logic [TAG_W-1:0] t1, input logic [63:0] d1);
    int  n;
    bit  rd0, rd1, a0, a1, byp;
    ent_t h;
    rst                 = r;
    bus.needToRestore_i = rs;
    bus.cdbStall_i      = st;
    bus.src0Valid_i     = v0;
    bus.src0Tag_i       = t0;
    bus.src0Val_i       = d0;
    bus.src1Valid_i     = v1;
    bus.src1Tag_i       = t1;
    bus.src1Val_i       = d1;
    n   = q.size();
    rd0 = (n <= DEPTH - 1);
    rd1 = (n <= DEPTH - 2);
    a0  = v0 && rd0 && (t0 != 0);
    a1  = v1 && rd1 && (t1 != 0);
    #1;
    chk({name, "/src0Ready"}, 65'(bus.src0Ready_o), 65'(rd0));
    chk({name, "/src1Ready"}, 65'(bus.src1Ready_o), 65'(rd1));
    @(posedge clk);
    if (r || rs) begin
      q.delete();
      m_tag = '0;
      m_val = '0;
    end else if (st) begin
      if (a0) push(t0, d0);
      if (a1) push(t1, d1);
    end else begin
      byp = 1'b0;
`ifdef CDB_BYPASS_EN
      if (n == 0 && a0) begin
        byp = 1'b1;
        accepted.push_back(t0);
        m_tag = t0;
        m_val = {1'b1, d0};
        if (a1) push(t1, d1);
      end else if (n == 0 && !v0 && a1) begin
        byp = 1'b1;
        accepted.push_back(t1);
        m_tag = t1;
        m_val = {1'b1, d1};
      end
`endif
      if (!byp) begin
        if (n > 0) begin
          h = q.pop_front();
          m_tag = h.tag;
          m_val = {1'b1, h.val};
        end else begin
          m_tag = '0;
          m_val = '0;
        end
        if (a0) push(t0, d0);
        if (a1) push(t1, d1);
      end
    end
    #1;
    chk({name, "/cdbTag"}, 65'(bus.cdbTag_o), 65'(m_tag));
    chk({name, "/cdbVal"}, bus.cdbVal_o, m_val);
    chk({name, "/occupancy"}, 65'(bus.occupancy_o), 65'(q.size()));
    chk({name, "/occ_range"}, 65'(bus.occupancy_o <= DEPTH), 65'(1));
    if (!r && !rs && !st && bus.cdbTag_o != '0) seen.push_back(bus.cdbTag_o);
  endtask

  task automatic idle(input string name, input int k);
    for (int i = 0; i < k; i++) cyc(name, 0, 0, 0, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    bus.needToRestore_i = 1'b0;
    bus.cdbStall_i      = 1'b0;
    bus.src0Valid_i     = 1'b0;
    bus.src0Tag_i       = '0;
    bus.src0Val_i       = '0;
    bus.src1Valid_i     = 1'b0;
    bus.src1Tag_i       = '0;
    bus.src1Val_i       = '0;

    cyc("reset", 1, 0, 0, 0, '0, '0, 0, '0, '0);
    cyc("reset", 1, 0, 0, 1, 5'd2, 64'h55, 1, 5'd4, 64'h66);
    chk("reset/tag_zero", 65'(bus.cdbTag_o), 65'(0));

    // Single ALU result and its fixed latency
    cyc("t1_feed", 0, 0, 0, 1, 5'd3, 64'hF0, 0, '0, '0);
`ifdef CDB_BYPASS_EN
    chk("t1_bypass_val", bus.cdbVal_o, 65'h1_0000_0000_0000_00F0);
    idle("t1_after", 1);
    chk("t1_gone", 65'(bus.cdbTag_o), 65'(0));
`else
    chk("t1_not_yet", 65'(bus.cdbTag_o), 65'(0));
    idle("t1_edge2", 1);
    chk("t1_val", bus.cdbVal_o, 65'h1_0000_0000_0000_00F0);
    idle("t1_after", 1);
    chk("t1_gone", 65'(bus.cdbTag_o), 65'(0));
`endif
    idle("t1_idle", 1);

    // Both sources in one cycle: src0 is older
    cyc("t2_feed", 0, 0, 0, 1, 5'd5, 64'hA, 1, 5'd6, 64'hB);
    idle("t2_drain", 4);

    // Fill under stall, then release
    for (int i = 1; i <= 4; i++) cyc("t3_fill", 0, 0, 1, 1, TAG_W'(i), 64'(i * 16), 0, '0, '0);
    cyc("t3_full", 0, 0, 1, 1, 5'd9, 64'h99, 1, 5'd10, 64'hAA);
    chk("t3_src0_blocked", 65'(bus.src0Ready_o), 65'(0));
    idle("t3_release", 6);

    // Null tag is dropped
    cyc("t4_null", 0, 0, 0, 1, 5'd0, 64'h1234, 0, '0, '0);
    idle("t4_idle", 2);

    // Restore flushes queued work and the same-cycle input
    for (int i = 1; i <= 3; i++) cyc("t5_fill", 0, 0, 1, 1, TAG_W'(i + 10), 64'(i), 0, '0, '0);
    cyc("t5_restore", 0, 1, 0, 1, 5'd7, 64'h1, 0, '0, '0);
    chk("t5_occ_zero", 65'(bus.occupancy_o), 65'(0));
    idle("t5_idle", 3);

    // Continuous input with alternating stall across pointer wrap
    accepted.delete();
    seen.delete();
    for (int i = 0; i < 3 * DEPTH; i++)
      cyc("t6_stream", 0, 0, (i % 2) == 1, 1, TAG_W'((i % 16) + 1), {$urandom, $urandom}, 0, '0, '0);
    idle("t6_drain", 2 * DEPTH);
    chk("t6_count", 65'(seen.size()), 65'(accepted.size()));
    for (int i = 0; i < accepted.size() && i < seen.size(); i++)
      chk("t6_order", 65'(seen[i]), 65'(accepted[i]));

    // Randomized traffic including null tags, stalls and restores
    for (int i = 0; i < 400; i++)
      cyc("rand", 0, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 30),
          1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, ROBSZ)), {$urandom, $urandom},
          1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, ROBSZ)), {$urandom, $urandom});
    idle("rand_drain", 2 * DEPTH);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
